// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder built from one full-adder slice and a carry flop.
// Adds two WIDTH-bit operands LSB first, one bit per clock, then pulses done.
//
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub input (a - b mod 2^WIDTH).
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE
//   a, b   operands, latched when start is accepted
//   cin    carry-in, latched when start is accepted
//   sub    subtract request (only with SERIAL_ADDER_SUB_EN)
//   busy   high while bits are being processed
//   done   one-cycle completion pulse
//   sum    result, holds the last completed value
//   cout   final carry, holds the last completed value
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds the low WIDTH-1 result bits; the MSB comes straight from the adder on the
    // completion edge.
    logic [WIDTH-2:0] res_q, res_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             fa_s, fa_c;
    logic [WIDTH-1:0] b_in;
    logic             c_in;

    // Full-adder slice on the current LSBs.
    assign fa_s = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);

    // Operand conditioning at latch time: subtract is a + ~b + 1.
    always_comb begin
        b_in = b;
        c_in = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_in = ~b;
            c_in = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        c_d     = c_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    a_sh_d  = a;
                    b_sh_d  = b_in;
                    c_d     = c_in;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                a_sh_d            = a_sh_q >> 1;
                b_sh_d            = b_sh_q >> 1;
                c_d               = fa_c;
                cnt_d             = cnt_q + CntW'(1);
                res_d             = res_q >> 1;
                res_d[WIDTH-2]    = fa_s;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StDone;
                    sum_d   = {fa_s, res_q};
                    cout_d  = fa_c;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8 and WIDTH=4).
// Define SERIAL_ADDER_SUB_EN to also exercise subtract mode.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       sub;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       sub4;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int vecs = 0;
    int errs = 0;

    logic [7:0] held_s;
    logic       held_c;
    int         ndone;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .cin   (cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub4),
`endif
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .cout  (cout4)
    );

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation on the 8-bit DUT with exact cycle-by-cycle timing checks.
    task automatic do_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic sv, input logic [7:0] es,
                         input logic ec);
        @(negedge clk);
        start = 1'b1; a = av; b = bv; cin = cv; sub = sv;
        @(negedge clk);
        // Scramble inputs so a re-sample would corrupt the result.
        start = 1'b0; a = ~av; b = ~bv; cin = ~cv; sub = ~sv;
        for (int i = 0; i < 8; i++) begin
            check({tag, " busy"}, {8'd0, busy}, 9'd1);
            check({tag, " done_lo"}, {8'd0, done}, 9'd0);
            check({tag, " held"}, {cout, sum}, {held_c, held_s});
            @(negedge clk);
        end
        check({tag, " done"}, {8'd0, done}, 9'd1);
        check({tag, " busy_lo"}, {8'd0, busy}, 9'd0);
        check({tag, " result"}, {cout, sum}, {ec, es});
        @(negedge clk);
        check({tag, " done_end"}, {8'd0, done}, 9'd0);
        check({tag, " result_hold"}, {cout, sum}, {ec, es});
        held_s = es;
        held_c = ec;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        held_s = 8'h00; held_c = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {8'd0, busy}, 9'd0);
        check("reset done", {8'd0, done}, 9'd0);
        check("reset result", {cout, sum}, 9'h000);
        check("reset4 result", {4'd0, cout4, sum4}, 9'h000);
        rst = 1'b0;

        do_op("add35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
        do_op("addff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        do_op("addff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

        // Start while busy must be ignored.
        @(negedge clk);
        start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3) begin
                start = 1'b1; a = 8'h80; b = 8'h80;
            end
            if (k == 8) start = 1'b0;
            if (done) ndone++;
            if (k == 9) check("busy_start result", {cout, sum}, 9'h003);
            @(negedge clk);
        end
        check("busy_start done count", ndone[8:0], 9'd1);
        held_s = 8'h03; held_c = 1'b0;

        // Reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; a = 8'h0F; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy", {8'd0, busy}, 9'd0);
        check("midrst done", {8'd0, done}, 9'd0);
        check("midrst result", {cout, sum}, 9'h000);
        held_s = 8'h00; held_c = 1'b0;
        do_op("after_rst", 8'h02, 8'h03, 1'b0, 1'b0, 8'h05, 1'b0);

        // Reset wins over start at the same edge.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_prio busy", {8'd0, busy}, 9'd0);

        // Back-to-back with start held high; also run the 4-bit instance.
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        start4 = 1'b1; a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) start4 = 1'b0;
            check("b2b done", {8'd0, done}, {8'd0, (k % 10) == 9});
            if ((k % 10) == 9) check("b2b result", {cout, sum}, 9'h030);
            if (k == 4) check("w4 done_lo", {8'd0, done4}, 9'd0);
            if (k == 5) begin
                check("w4 done", {8'd0, done4}, 9'd1);
                check("w4 result", {4'd0, cout4, sum4}, 9'h010);
            end
        end
        start = 1'b0;
        repeat (12) @(negedge clk);
        held_s = 8'h30; held_c = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
        do_op("sub20_10", 8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1);
        do_op("sub10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0);
        do_op("sub0_add", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
